// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Byte stream from the UART receive controller to the command decoder.
//   m_valid  byte available in the one-entry buffer
//   m_data   received byte
//   m_perr   parity error flag for m_data
//   m_ferr   frame error flag for m_data
//   m_ready  consumer accepts when m_valid & m_ready
// master: the controller (drives valid/data/flags); slave: the consumer.
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ready;

    modport master (output m_valid, m_data, m_perr, m_ferr, input m_ready);
    modport slave  (input m_valid, m_data, m_perr, m_ferr, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Sits in front of the UART receiver core. Generates the oversampling tick,
// owns the runtime frame configuration (applied only between frames) and
// buffers each received byte with its error flags for the command decoder.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   cfg_wr, cfg_*        strobe + values captured (sanitised) into pending config
//   rx                   synchronised serial line (same signal the core sees)
//   s_tick               oversample tick to the core
//   data_bits, stop_bits, parity_bits   active frame config to the core
//   rx_done_tick, rx_dout, rx_parity_error, rx_frame_error   core outputs
//   m_if                 one-entry valid/ready byte buffer (master side)
//   overrun, ovr_clr     sticky dropped-byte flag and its clear
//   perr_cnt, ferr_cnt, cnt_clr   saturating error counters and their clear
//   busy                 frame in progress or config change pending
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter logic [15:0] DIV_DEFAULT = 16'd325,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_wr,
    input  logic [15:0]      cfg_div,
    input  logic [3:0]       cfg_data_bits,
    input  logic [5:0]       cfg_stop_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             rx,
    output logic             s_tick,
    output logic [3:0]       data_bits,
    output logic [5:0]       stop_bits,
    output logic [1:0]       parity_bits,
    input  logic             rx_done_tick,
    input  logic [7:0]       rx_dout,
    input  logic             rx_parity_error,
    input  logic             rx_frame_error,
    uart_rx_ctrl_if.master   m_if,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic [CNT_W-1:0] perr_cnt,
    output logic [CNT_W-1:0] ferr_cnt,
    input  logic             cnt_clr,
    output logic             busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state_q, state_d;

    logic [15:0] act_div;
    logic [15:0] tick_cnt;

    logic        pending;
    logic [15:0] pend_div;
    logic [3:0]  pend_data_bits;
    logic [5:0]  pend_stop_bits;
    logic [1:0]  pend_parity;

    logic [3:0]  san_data_bits;
    logic [5:0]  san_stop_bits;
    logic [1:0]  san_parity;
    logic        apply;

    logic        done_d;
    logic        valid_q;
    logic [7:0]  data_q;
    logic        perr_q;
    logic        ferr_q;
    logic        buf_free;
    logic        cap_perr;

    // ---------------------------------------------------------------------
    // Frame tracking FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx)         state_d = ACTIVE;
            ACTIVE:  if (rx_done_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Configuration: sanitise at capture, apply only between frames
    // ---------------------------------------------------------------------
    assign san_data_bits = (cfg_data_bits == 4'd7 || cfg_data_bits == 4'd8) ? cfg_data_bits : 4'd8;
    assign san_stop_bits = (cfg_stop_bits == 6'd0) ? 6'd16 : cfg_stop_bits;
    assign san_parity    = (cfg_parity == 2'd3) ? 2'd0 : cfg_parity;

    // Line high and FSM idle: no frame is being sampled by the core.
    assign apply = pending && (state_q == IDLE) && rx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_div        <= DIV_DEFAULT;
            data_bits      <= 4'd8;
            stop_bits      <= 6'd16;
            parity_bits    <= 2'd0;
            pending        <= 1'b0;
            pend_div       <= DIV_DEFAULT;
            pend_data_bits <= 4'd8;
            pend_stop_bits <= 6'd16;
            pend_parity    <= 2'd0;
        end else begin
            if (apply) begin
                act_div     <= pend_div;
                data_bits   <= pend_data_bits;
                stop_bits   <= pend_stop_bits;
                parity_bits <= pend_parity;
            end
            // A write landing on the apply cycle becomes the next pending set.
            if (cfg_wr) begin
                pend_div       <= cfg_div;
                pend_data_bits <= san_data_bits;
                pend_stop_bits <= san_stop_bits;
                pend_parity    <= san_parity;
                pending        <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Oversample tick: counter 0..div-1, tick on the last count.
    // Divisors 0 and 1 both mean a tick every cycle.
    // ---------------------------------------------------------------------
    assign s_tick = (act_div <= 16'd1) || (tick_cnt == act_div - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= 16'd0;
        end else if (apply || s_tick) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Byte path: the core's error flags settle one cycle after its done
    // pulse, so everything is captured on the delayed pulse.
    // ---------------------------------------------------------------------
    assign buf_free = !valid_q || m_if.m_ready;
    assign cap_perr = rx_parity_error && (parity_bits != 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_d  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'd0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done_d <= rx_done_tick;

            if (done_d && buf_free) begin
                valid_q <= 1'b1;
                data_q  <= rx_dout;
                perr_q  <= cap_perr;
                ferr_q  <= rx_frame_error;
            end else if (valid_q && m_if.m_ready) begin
                valid_q <= 1'b0;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (done_d && !buf_free) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign m_if.m_valid = valid_q;
    assign m_if.m_data  = data_q;
    assign m_if.m_perr  = perr_q;
    assign m_if.m_ferr  = ferr_q;

    // ---------------------------------------------------------------------
    // Saturating error counters; dropped bytes still count, clear wins.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_cnt <= '0;
            ferr_cnt <= '0;
        end else if (cnt_clr) begin
            perr_cnt <= '0;
            ferr_cnt <= '0;
        end else if (done_d) begin
            if (cap_perr && perr_cnt != CNT_MAX) begin
                perr_cnt <= perr_cnt + CNT_ONE;
            end
            if (rx_frame_error && ferr_cnt != CNT_MAX) begin
                ferr_cnt <= ferr_cnt + CNT_ONE;
            end
        end
    end

    assign busy = (state_q == ACTIVE) || pending;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_wr;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_data_bits;
    logic [5:0]  cfg_stop_bits;
    logic [1:0]  cfg_parity;
    logic        rx;
    logic        s_tick;
    logic [3:0]  data_bits;
    logic [5:0]  stop_bits;
    logic [1:0]  parity_bits;
    logic        rx_done_tick;
    logic [7:0]  rx_dout;
    logic        rx_parity_error;
    logic        rx_frame_error;
    logic        overrun;
    logic        ovr_clr;
    logic [7:0]  perr_cnt;
    logic [7:0]  ferr_cnt;
    logic        cnt_clr;
    logic        busy;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(.DIV_DEFAULT(16'd325), .CNT_W(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_wr          (cfg_wr),
        .cfg_div         (cfg_div),
        .cfg_data_bits   (cfg_data_bits),
        .cfg_stop_bits   (cfg_stop_bits),
        .cfg_parity      (cfg_parity),
        .rx              (rx),
        .s_tick          (s_tick),
        .data_bits       (data_bits),
        .stop_bits       (stop_bits),
        .parity_bits     (parity_bits),
        .rx_done_tick    (rx_done_tick),
        .rx_dout         (rx_dout),
        .rx_parity_error (rx_parity_error),
        .rx_frame_error  (rx_frame_error),
        .m_if            (bus),
        .overrun         (overrun),
        .ovr_clr         (ovr_clr),
        .perr_cnt        (perr_cnt),
        .ferr_cnt        (ferr_cnt),
        .cnt_clr         (cnt_clr),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Reference model: expected byte stream plus error-count totals.
    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       f;
    } byte_t;

    byte_t exp_q[$];
    int    exp_perr;
    int    exp_ferr;
    int    cur_parity;
    int    n_vec;
    int    n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: score any handshake happening at this edge, then move to
    // 1ns past the edge where outputs are stable and inputs may be driven.
    task automatic step();
        byte_t e;
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            check("sb_queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_data", bus.m_data, e.d);
                check("sb_perr", bus.m_perr, e.p);
                check("sb_ferr", bus.m_ferr, e.f);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_count(input logic pe, input logic fe);
        if (pe && cur_parity != 0 && exp_perr != 255) exp_perr++;
        if (fe && exp_ferr != 255) exp_ferr++;
    endtask

    // Done pulse in cycle T, error flags valid in T+1.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic fe, input bit drop);
        rx_dout      = d;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick    = 1'b0;
        rx_parity_error = pe;
        rx_frame_error  = fe;
        if (!drop) exp_q.push_back('{d, pe && (cur_parity != 0), fe});
        model_count(pe, fe);
        step();
    endtask

    task automatic write_cfg(input logic [15:0] dv, input logic [3:0] db, input logic [5:0] sb, input logic [1:0] pb);
        cfg_div       = dv;
        cfg_data_bits = db;
        cfg_stop_bits = sb;
        cfg_parity    = pb;
        cfg_wr        = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic measure_ticks(input int cycles, input int period, input string tag);
        int last;
        int nticks;
        last   = -1;
        nticks = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (s_tick) begin
                if (last >= 0) check(tag, i - last, period);
                last = i;
                nticks++;
            end
        end
        check({tag, "_seen"}, nticks >= 2, 1);
    endtask

    initial begin
        logic [7:0] d;
        logic       pe;
        logic       fe;

        n_vec = 0; n_err = 0;
        exp_perr = 0; exp_ferr = 0; cur_parity = 0;
        reset_n = 1'b0;
        cfg_wr = 1'b0; cfg_div = 16'd0; cfg_data_bits = 4'd0; cfg_stop_bits = 6'd0; cfg_parity = 2'd0;
        rx = 1'b1; rx_done_tick = 1'b0; rx_dout = 8'd0;
        rx_parity_error = 1'b0; rx_frame_error = 1'b0;
        bus.m_ready = 1'b0; ovr_clr = 1'b0; cnt_clr = 1'b0;

        // Reset values
        #23;
        check("rst_data_bits", data_bits, 8);
        check("rst_stop_bits", stop_bits, 16);
        check("rst_parity", parity_bits, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_perr_cnt", perr_cnt, 0);
        check("rst_ferr_cnt", ferr_cnt, 0);
        check("rst_s_tick", s_tick, 0);
        reset_n = 1'b1;

        // Idle with default divisor
        measure_ticks(700, 325, "tick_div325");
        check("idle_busy", busy, 0);
        check("idle_m_valid", bus.m_valid, 0);

        // Config change while idle
        write_cfg(16'd4, 4'd7, 6'd32, 2'd1);
        check("cfg_busy_pending", busy, 1);
        check("cfg_not_yet_applied", data_bits, 8);
        step();
        check("cfg_data_bits", data_bits, 7);
        check("cfg_stop_bits", stop_bits, 32);
        check("cfg_parity", parity_bits, 1);
        check("cfg_busy_after", busy, 0);
        cur_parity = 1;
        measure_ticks(20, 4, "tick_div4");

        // Config written mid-frame is held until the frame ends
        rx = 1'b0;
        step();
        check("frame_busy", busy, 1);
        write_cfg(16'd0, 4'd9, 6'd0, 2'd3);
        repeat (5) step();
        check("mid_frame_data_bits", data_bits, 7);
        check("mid_frame_parity", parity_bits, 1);
        check("mid_frame_busy", busy, 1);
        rx = 1'b1;
        bus.m_ready = 1'b1;
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        check("late_apply_data_bits", data_bits, 8);
        check("late_apply_stop_bits", stop_bits, 16);
        check("late_apply_parity", parity_bits, 0);
        check("late_apply_busy", busy, 0);
        cur_parity = 0;
        measure_ticks(10, 1, "tick_div0");

        // Latency, frame error capture and overrun
        bus.m_ready = 1'b0;
        step();
        rx_dout = 8'h5A;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        rx_parity_error = 1'b0;
        rx_frame_error = 1'b1;
        exp_q.push_back('{8'h5A, 1'b0, 1'b1});
        model_count(1'b0, 1'b1);
        check("latency_t1_m_valid", bus.m_valid, 0);
        step();
        check("latency_t2_m_valid", bus.m_valid, 1);
        check("first_m_data", bus.m_data, 8'h5A);
        check("first_m_ferr", bus.m_ferr, 1);
        check("first_m_perr", bus.m_perr, 0);
        check("first_ferr_cnt", ferr_cnt, exp_ferr);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        check("ovr_set", overrun, 1);
        check("ovr_m_valid", bus.m_valid, 1);
        check("ovr_m_data_kept", bus.m_data, 8'h5A);
        check("ovr_ferr_cnt_counts_drop", ferr_cnt, exp_ferr);
        // Drop and clear in the same cycle: drop wins
        rx_dout = 8'hC3;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        rx_frame_error = 1'b0;
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ovr_clr_vs_drop", overrun, 1);
        check("ovr_m_data_kept2", bus.m_data, 8'h5A);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        bus.m_ready = 1'b1;
        step();
        step();
        check("drained_m_valid", bus.m_valid, 0);

        // Back-to-back frames every two cycles with consumer always ready
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            fe = 1'($urandom);
            send_frame(d, pe, fe, 1'b0);
        end
        rx_frame_error = 1'b0;
        repeat (3) step();
        check("b2b_overrun", overrun, 0);
        check("b2b_drained", exp_q.size(), 0);
        check("b2b_m_valid", bus.m_valid, 0);
        check("b2b_ferr_cnt", ferr_cnt, exp_ferr);
        check("b2b_perr_cnt", perr_cnt, exp_perr);

        // Parity errors saturate the counter
        write_cfg(16'd4, 4'd8, 6'd16, 2'd2);
        step();
        check("par2_parity_bits", parity_bits, 2);
        cur_parity = 2;
        for (int i = 0; i < 300; i++) begin
            send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        end
        repeat (3) step();
        check("perr_saturated", perr_cnt, exp_perr);
        check("perr_model_255", exp_perr, 255);
        check("sat_drained", exp_q.size(), 0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_perr = 0;
        exp_ferr = 0;
        check("clr_perr_cnt", perr_cnt, 0);
        check("clr_ferr_cnt", ferr_cnt, 0);
        // Clear collides with an increment: clear wins
        rx_dout = 8'h3C;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        rx_parity_error = 1'b1;
        cnt_clr = 1'b1;
        exp_q.push_back('{8'h3C, 1'b1, 1'b0});
        step();
        cnt_clr = 1'b0;
        check("clr_wins_perr_cnt", perr_cnt, 0);

        // Parity disabled: flag masked and not counted
        write_cfg(16'd4, 4'd8, 6'd16, 2'd0);
        step();
        cur_parity = 0;
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        repeat (2) step();
        check("par0_perr_cnt", perr_cnt, exp_perr);
        check("par0_drained", exp_q.size(), 0);

        // Reset with a buffered byte, an active frame and a pending config
        bus.m_ready = 1'b0;
        rx_parity_error = 1'b0;
        send_frame(8'hEE, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        step();
        write_cfg(16'd4, 4'd7, 6'd8, 2'd1);
        check("pre_rst_m_valid", bus.m_valid, 1);
        check("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #2;
        exp_q.delete();
        exp_perr = 0;
        exp_ferr = 0;
        cur_parity = 0;
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data_bits", data_bits, 8);
        rx = 1'b1;
        #3;
        reset_n = 1'b1;
        repeat (3) step();
        check("post_rst_busy", busy, 0);
        check("post_rst_data_bits", data_bits, 8);
        check("post_rst_parity", parity_bits, 0);
        measure_ticks(700, 325, "tick_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
